pc_sequencer: RTL

Program-counter sequencer for the ECP8 core, directly downstream of the condition evaluator. Consumes its 1-bit branch decision and the decoded control op, and produces the next instruction address. Supports conditional jump, conditional call and return through a small hardware return stack, with sticky fault flags for stack overflow and underflow.

---
 rtl/ecp8_pkg.sv | 15 +
 rtl/pc_return_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/ecp8_pkg.sv
// Shared definitions for the ECP8 program-counter sequencer: op encodings
// and fault flag bit positions.
package ecp8_pkg;

    typedef enum logic [1:0] {
        OP_NEXT = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam int FAULT_OVF = 0;
    localparam int FAULT_UDF = 1;

endpackage

// File: rtl/pc_return_stack.sv
// Parameterized LIFO holding return addresses; rdata always shows the top
// entry (don't-care when empty). The parent never pushes and pops together.
module pc_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    top_idx;

    // DEPTH is a power of two, so the low bits of the count index the free slot.
    assign wr_idx  = count[PW-1:0];
    assign top_idx = wr_idx - PW'(1);
    assign rdata   = entries[top_idx];
    assign depth   = count;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count <= '0;
        end else if (push && !full) begin
            entries[wr_idx] <= wdata;
            count           <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && pop))
        else $error("pc_return_stack: push and pop asserted together");

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection for NEXT/JUMP/CALL/RET with a
// hardware return stack, registered redirect pulse and sticky stack faults.
module pc_sequencer
    import ecp8_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    UUID        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step,
    input  logic [1:0]                    op,
    input  logic                          cond_result,
    input  logic [ADDR_WIDTH-1:0]         target,
    output logic [ADDR_WIDTH-1:0]         pc,
    output logic                          redirect,
    output logic [$clog2(STACK_DEPTH):0]  depth,
    output logic [1:0]                    fault
);
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic                  redirect_next;
    logic [1:0]            fault_next;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign pc_inc = pc + ADDR_WIDTH'(1);

    pc_return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (ret_addr),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // A refused CALL or RET falls back to sequential flow and only records a fault.
    always_comb begin
        pc_next       = pc;
        redirect_next = 1'b0;
        fault_next    = fault;
        push          = 1'b0;
        pop           = 1'b0;
        if (step) begin
            pc_next = pc_inc;
            case (op_e'(op))
                OP_JUMP: begin
                    if (cond_result) begin
                        pc_next       = target;
                        redirect_next = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (cond_result) begin
                        if (!full) begin
                            push          = 1'b1;
                            pc_next       = target;
                            redirect_next = 1'b1;
                        end else begin
                            fault_next[FAULT_OVF] = 1'b1;
                        end
                    end
                end
                OP_RET: begin
                    if (!empty) begin
                        pop           = 1'b1;
                        pc_next       = ret_addr;
                        redirect_next = 1'b1;
                    end else begin
                        fault_next[FAULT_UDF] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            redirect <= 1'b0;
            fault    <= 2'b00;
        end else begin
            pc       <= pc_next;
            redirect <= redirect_next;
            fault    <= fault_next;
        end
    end

    assert property (@(posedge clk) disable iff (rst) depth <= ($clog2(STACK_DEPTH)+1)'(STACK_DEPTH))
        else $error("pc_sequencer %0d: stack depth out of range", UUID);

endmodule
